// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: size encodings, bus FSM states, queued entry layout.
package store_buffer_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    BEGIN,
    DATA
  } state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

endpackage

// File: rtl/store_fifo.sv
// In-order entry queue for the store buffer; count is one bit wider than the pointers.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store lane steering, queueing and single-beat bus write FSM.
// Optional STORE_BUFFER_ALIGN_CHECK_EN drops misaligned stores and pulses alignError.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        storeValid,
  input  logic [1:0]  storeSize,
  input  logic [31:0] storeAddress,
  input  logic [31:0] storeData,
  output logic        storeReady,
  output logic        bufferEmpty,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        beginTransaction,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnables,
  output logic        readNotWrite,
  input  logic        endTransaction,
  input  logic        busError,
  output logic        storeBusError
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
  ,
  output logic        alignError
`endif
);

  state_t      state;
  state_t      state_next;
  entry_t      head;
  entry_t      push_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        accept;
  logic        bus_err_q;
  logic [31:0] steer_data;
  logic [3:0]  steer_be;

  // Big-endian lane steering: address offset 0 lives in bits [31:24].
  always_comb begin
    steer_data = storeData;
    steer_be   = 4'b1111;
    case (storeSize)
      SIZE_BYTE: begin
        steer_data = {4{storeData[7:0]}};
        steer_be   = 4'b1000 >> storeAddress[1:0];
      end
      SIZE_HALF: begin
        steer_data = {2{storeData[15:0]}};
        steer_be   = storeAddress[1] ? 4'b0011 : 4'b1100;
      end
      SIZE_WORD, 2'b11: begin
        steer_data = storeData;
        steer_be   = 4'b1111;
      end
    endcase
  end

  assign push_entry = '{addr: storeAddress[31:2], data: steer_data, be: steer_be};
  assign storeReady = !fifo_full && !reset;
  assign accept     = storeValid && storeReady;

`ifdef STORE_BUFFER_ALIGN_CHECK_EN
  logic misaligned;
  logic align_err_q;

  assign misaligned = ((storeSize == SIZE_HALF) && storeAddress[0]) ||
                      (storeSize[1] && (storeAddress[1:0] != 2'b00));
  assign push       = accept && !misaligned;
  assign alignError = align_err_q && !reset;

  always_ff @(posedge clock) begin
    if (reset) align_err_q <= 1'b0;
    else       align_err_q <= accept && misaligned;
  end
`else
  assign push = accept;
`endif

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bus outputs decode from state; reset forces them low in the same cycle.
  always_comb begin
    state_next       = state;
    busRequest       = 1'b0;
    beginTransaction = 1'b0;
    addressDataOut   = '0;
    byteEnables      = '0;
    pop              = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_next = REQUEST;
      end
      REQUEST: begin
        busRequest = 1'b1;
        if (busGrant) state_next = BEGIN;
      end
      BEGIN: begin
        busRequest       = 1'b1;
        beginTransaction = 1'b1;
        addressDataOut   = {head.addr, 2'b00};
        byteEnables      = head.be;
        state_next       = DATA;
      end
      DATA: begin
        busRequest     = 1'b1;
        addressDataOut = head.data;
        if (endTransaction || busError) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      state_next       = IDLE;
      busRequest       = 1'b0;
      beginTransaction = 1'b0;
      addressDataOut   = '0;
      byteEnables      = '0;
      pop              = 1'b0;
    end
  end

  // A failed beat is dropped, never retried; report it one cycle later.
  always_ff @(posedge clock) begin
    if (reset) bus_err_q <= 1'b0;
    else       bus_err_q <= (state == DATA) && busError;
  end

  assign storeBusError = bus_err_q && !reset;
  assign bufferEmpty   = fifo_empty && (state == IDLE) && !reset;
  assign readNotWrite  = 1'b0;

endmodule
